// File: rtl/save_restore_ctrl_if.sv
// Retention-memory request port: one request (read or write) held until the memory acks it.
interface save_restore_ctrl_if #(
  parameter int unsigned K = 32,
  parameter int unsigned M = 32
);
  logic         ReadMem;
  logic         WriteMem;
  logic [K-1:0] AddrMem;
  logic [M-1:0] WDataMem;
  logic         AckMem;
  logic [M-1:0] ValMem;

  modport master (
    output ReadMem,
    output WriteMem,
    output AddrMem,
    output WDataMem,
    input  AckMem,
    input  ValMem
  );

  modport slave (
    input  ReadMem,
    input  WriteMem,
    input  AddrMem,
    input  WDataMem,
    output AckMem,
    output ValMem
  );
endinterface

// File: rtl/save_restore_ctrl.sv
// Save/restore controller: streams N wrapper words to retention memory (SAVE) or back into
// the wrappers through a one-hot load strobe (RESTORE), with per-word ack timeout.
module save_restore_ctrl #(
  parameter int unsigned N       = 10,
  parameter int unsigned K       = 32,
  parameter int unsigned M       = 32,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Pwr_off,
  input  logic                  Start,
  input  logic                  Mode,
  input  logic [K-1:0]          BaseAddr,
  input  logic [N*M-1:0]        SaveVal,
  save_restore_ctrl_if.master   mem,
  output logic [M-1:0]          RestoreVal,
  output logic [N-1:0]          RestoreEn,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int unsigned    IW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
  localparam logic [K-1:0]   STRIDE_K = K'(STRIDE);
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FIN    = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           mode_q, mode_d;
  logic [K-1:0]   addr_q, addr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   rval_q, rval_d;
  logic [N-1:0]   ren_q, ren_d;

  logic           read_req;
  logic           write_req;
  logic           busy_w;
  logic           done_w;
  logic           err_w;
  logic           srst;

  logic [M-1:0]   save_words [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign save_words[gi] = SaveVal[gi*M +: M];
  end

  // Power-off behaves exactly like reset: abort without Done and clear restore outputs.
  assign srst = Rst | Pwr_off;

  always_ff @(posedge Clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rval_q  <= '0;
      ren_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rval_q  <= rval_d;
      ren_q   <= ren_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rval_d    = '0;
    ren_d     = '0;
    read_req  = 1'b0;
    write_req = 1'b0;
    busy_w    = 1'b0;
    done_w    = 1'b0;
    err_w     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          addr_d  = BaseAddr;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        busy_w    = 1'b1;
        read_req  = ~mode_q;
        write_req = mode_q;
        if (mem.AckMem) begin
          cnt_d = '0;
          if (!mode_q) begin
            rval_d = mem.ValMem;
            ren_d  = N'(1) << idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            idx_d  = idx_q + IW'(1);
            addr_d = addr_q + STRIDE_K;
          end
        end else if (TIMEOUT != 0) begin
          // The request has been visible for TIMEOUT cycles once this wait cycle ends.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_FIN: begin
        busy_w  = 1'b1;
        done_w  = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        busy_w  = 1'b1;
        done_w  = 1'b1;
        err_w   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem.ReadMem  = read_req;
  assign mem.WriteMem = write_req;
  assign mem.AddrMem  = (read_req | write_req) ? addr_q : '0;
  assign mem.WDataMem = write_req ? save_words[idx_q] : '0;

  assign RestoreVal = rval_q;
  assign RestoreEn  = ren_q;
  assign Busy       = busy_w;
  assign Done       = done_w;
  assign Err        = err_w;

endmodule

// File: tb/tb_save_restore_ctrl.sv
// Randomized bench: two controllers (STRIDE 4 and 1) share stimulus and are compared every
// cycle against a transfer-level reference model.
module tb_save_restore_ctrl;

  localparam int N   = 4;
  localparam int TO  = 5;
  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_FIN  = 2;
  localparam int P_ERR  = 3;

  logic          Clk = 1'b0;
  logic          Rst, Pwr_off, Start, Mode;
  logic [31:0]   BaseAddr;
  logic [127:0]  save_val;
  logic          ack;
  logic [31:0]   val;

  logic [31:0] rval1, rval2;
  logic [3:0]  ren1, ren2;
  logic        busy1, busy2, done1, done2, err1, err2;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_phase, m_word, m_wait;
  bit          m_mode;
  logic [31:0] m_base;
  logic [3:0]  m_ren;
  logic [31:0] m_rval;

  // stimulus policy
  int ack_delay = 0;
  int hang_word = -1;
  bit noise_ack = 0;

  always #5 Clk = ~Clk;

  save_restore_ctrl_if #(.K(32), .M(32)) if1 ();
  save_restore_ctrl_if #(.K(32), .M(32)) if2 ();

  assign if1.AckMem = ack;
  assign if2.AckMem = ack;
  assign if1.ValMem = val;
  assign if2.ValMem = val;

  save_restore_ctrl #(.N(N), .K(32), .M(32), .STRIDE(4), .TIMEOUT(TO)) dut1 (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Start(Start), .Mode(Mode),
    .BaseAddr(BaseAddr), .SaveVal(save_val), .mem(if1),
    .RestoreVal(rval1), .RestoreEn(ren1), .Busy(busy1), .Done(done1), .Err(err1)
  );

  save_restore_ctrl #(.N(N), .K(32), .M(32), .STRIDE(1), .TIMEOUT(TO)) dut2 (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Start(Start), .Mode(Mode),
    .BaseAddr(BaseAddr), .SaveVal(save_val), .mem(if2),
    .RestoreVal(rval2), .RestoreEn(ren2), .Busy(busy2), .Done(done2), .Err(err2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_word  = 0;
    m_wait  = 0;
    m_mode  = 0;
    m_base  = '0;
    m_ren   = '0;
    m_rval  = '0;
  endtask

  // One clock of the transfer-level model, using the inputs present at this edge.
  task automatic model_step();
    logic [3:0]  new_ren;
    logic [31:0] new_val;
    new_ren = '0;
    new_val = '0;
    if (Rst || Pwr_off) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE: if (Start) begin
        m_phase = P_ACC;
        m_word  = 0;
        m_wait  = 0;
        m_mode  = Mode;
        m_base  = BaseAddr;
      end
      P_ACC: if (ack) begin
        if (!m_mode) begin
          new_ren = 4'(1 << m_word);
          new_val = val;
        end
        m_wait = 0;
        if (m_word == N - 1) m_phase = P_FIN;
        else m_word++;
      end else begin
        m_wait++;
        if (m_wait == TO) m_phase = P_ERR;
      end
      default: m_phase = P_IDLE;
    endcase
    m_ren  = new_ren;
    m_rval = new_val;
  endtask

  task automatic check_outputs();
    bit          acc, e_rd, e_wr;
    logic [31:0] e_a1, e_a2, e_wd;
    acc  = (m_phase == P_ACC);
    e_rd = acc && !m_mode;
    e_wr = acc && m_mode;
    e_a1 = acc ? m_base + 32'(m_word * 4) : 32'h0;
    e_a2 = acc ? m_base + 32'(m_word) : 32'h0;
    e_wd = e_wr ? save_val[m_word*32 +: 32] : 32'h0;
    check("d1.busy", busy1, m_phase != P_IDLE);
    check("d1.done", done1, m_phase == P_FIN || m_phase == P_ERR);
    check("d1.err", err1, m_phase == P_ERR);
    check("d1.read", if1.ReadMem, e_rd);
    check("d1.write", if1.WriteMem, e_wr);
    check("d1.addr", if1.AddrMem, e_a1);
    check("d1.wdata", if1.WDataMem, e_wd);
    check("d1.ren", ren1, m_ren);
    check("d1.rval", rval1, m_rval);
    check("d2.busy", busy2, m_phase != P_IDLE);
    check("d2.done", done2, m_phase == P_FIN || m_phase == P_ERR);
    check("d2.err", err2, m_phase == P_ERR);
    check("d2.read", if2.ReadMem, e_rd);
    check("d2.write", if2.WriteMem, e_wr);
    check("d2.addr", if2.AddrMem, e_a2);
    check("d2.wdata", if2.WDataMem, e_wd);
    check("d2.ren", ren2, m_ren);
    check("d2.rval", rval2, m_rval);
  endtask

  task automatic cycle();
    if (m_phase == P_ACC) ack = (m_wait >= ack_delay) && (m_word != hang_word);
    else ack = noise_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    val      = $urandom();
    save_val = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge Clk);
    check_outputs();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_transfer(input bit mode, input logic [31:0] base, input int delay,
                              input int hang, input bit spam, input int abort_at);
    int n;
    ack_delay = delay;
    hang_word = hang;
    Start     = 1'b1;
    Mode      = mode;
    BaseAddr  = base;
    cycle();
    Start = 1'b0;
    n = 0;
    while (m_phase != P_IDLE && n < 64) begin
      if (spam) begin
        Start    = 1'($urandom_range(0, 1));
        Mode     = 1'($urandom_range(0, 1));
        BaseAddr = $urandom();
      end
      Pwr_off = (n == abort_at);
      cycle();
      n++;
    end
    Start   = 1'b0;
    Pwr_off = 1'b0;
    $display("xfer mode=%0d base=%h delay=%0d hang=%0d spam=%0d abort=%0d cycles=%0d checks=%0d errors=%0d",
             mode, base, delay, hang, spam, abort_at, n, n_checks, n_errors);
    cycle();
  endtask

  initial begin
    int n;
    Rst = 1'b1; Pwr_off = 1'b0; Start = 1'b1; Mode = 1'b1; BaseAddr = 32'h55;
    ack = 1'b0; val = '0; save_val = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    repeat (3) cycle();
    Rst = 1'b0; Start = 1'b0;
    noise_ack = 1;
    repeat (2) cycle();

    run_transfer(1'b0, 32'h100, 0, -1, 1'b0, -1);
    run_transfer(1'b1, 32'h100, 3, -1, 1'b0, -1);
    run_transfer(1'b0, 32'h200, 0, 2, 1'b0, -1);

    // power-off while word 1 of a restore is outstanding, then restart from word 0
    ack_delay = 2; hang_word = -1;
    Start = 1'b1; Mode = 1'b0; BaseAddr = 32'h300;
    cycle();
    Start = 1'b0;
    n = 0;
    while (!(m_phase == P_ACC && m_word == 1) && n < 20) begin
      cycle();
      n++;
    end
    Pwr_off = 1'b1; Start = 1'b1;
    repeat (2) cycle();
    Pwr_off = 1'b0; Start = 1'b0;
    cycle();
    $display("pwr_off abort: checks=%0d errors=%0d", n_checks, n_errors);
    run_transfer(1'b0, 32'h300, 0, -1, 1'b0, -1);

    run_transfer(1'b0, 32'hFFFF_FFFE, 1, -1, 1'b0, -1);
    run_transfer(1'b1, 32'hFFFF_FFFE, 0, -1, 1'b0, -1);
    run_transfer(1'b0, 32'h400, 1, -1, 1'b1, -1);

    // reset held mid-transfer with Start asserted
    ack_delay = 1; hang_word = -1;
    Start = 1'b1; Mode = 1'b1; BaseAddr = 32'h500;
    cycle();
    Start = 1'b0;
    repeat (3) cycle();
    Rst = 1'b1; Start = 1'b1;
    repeat (2) cycle();
    Rst = 1'b0; Start = 1'b0;
    cycle();
    $display("rst abort: checks=%0d errors=%0d", n_checks, n_errors);

    repeat (40) begin
      run_transfer(1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 6),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
